// File: rtl/video_input_packer.sv
`default_nettype none
// ============================================================================
// Module   : video_input_packer
// Purpose  : Packs a DE/VSYNC pixel stream into double-buffered RAM words and
//            qualifies the frame geometry before flagging a settled bank.
// Revision : 1.0 - initial release
// ============================================================================
module video_input_packer #(
   parameter int CHANNEL_COUNT = 3,
   parameter int COLOR_WIDTH   = 8,
   parameter int BATCH_SIZE    = 4,
   parameter int BLOCK_DEPTH   = 480,
   parameter int BANK_COUNT    = 2,
   parameter int MAX_WIDTH     = 64,
   parameter int MAX_HEIGHT    = 64,
   parameter int STABLE_FRAMES = 2,
   localparam int LANE_W = COLOR_WIDTH * BATCH_SIZE,
   localparam int ADDR_W = (BLOCK_DEPTH > 1) ? $clog2(BLOCK_DEPTH) : 1,
   localparam int BANK_W = (BANK_COUNT > 1) ? $clog2(BANK_COUNT) : 1,
   localparam int IW_W   = $clog2(MAX_WIDTH + 1),
   localparam int IH_W   = $clog2(MAX_HEIGHT + 1)
) (
   input  logic                              rgb_clk,
   input  logic                              rst_n,
   input  logic                              rgb_de,
   input  logic                              rgb_vs,
   input  logic                              vs_pol,
   input  logic [CHANNEL_COUNT*COLOR_WIDTH-1:0] rgb_color,
   output logic [CHANNEL_COUNT*LANE_W-1:0]   wr_data,
   output logic [ADDR_W-1:0]                 wr_addr,
   output logic [BANK_W-1:0]                 wr_bank,
   output logic                              wr_en,
   output logic                              frame_done,
   output logic [BANK_W-1:0]                 ready_bank,
   output logic                              overflow,
   output logic [IW_W-1:0]                   image_width,
   output logic [IH_W-1:0]                   image_height,
   output logic                              image_valid
);

   localparam int ACNT_W = $clog2(BLOCK_DEPTH + 1);
   localparam int LEN_W  = $clog2(MAX_WIDTH + 2);
   localparam int LCNT_W = $clog2(MAX_HEIGHT + 2);
   localparam int SLOT_W = (BATCH_SIZE > 1) ? $clog2(BATCH_SIZE) : 1;
   localparam int STAB_W = $clog2(STABLE_FRAMES + 1);

   localparam logic [LEN_W-1:0]  LEN_MAX    = LEN_W'(MAX_WIDTH);
   localparam logic [LEN_W-1:0]  LEN_SAT    = LEN_W'(MAX_WIDTH + 1);
   localparam logic [LCNT_W-1:0] LCNT_MAX   = LCNT_W'(MAX_HEIGHT);
   localparam logic [LCNT_W-1:0] LCNT_SAT   = LCNT_W'(MAX_HEIGHT + 1);
   localparam logic [ACNT_W-1:0] ADDR_LIMIT = ACNT_W'(BLOCK_DEPTH);
   localparam logic [STAB_W-1:0] STAB_SAT   = STAB_W'(STABLE_FRAMES);
   localparam logic [BANK_W-1:0] BANK_LAST  = BANK_W'(BANK_COUNT - 1);
   localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(BATCH_SIZE - 1);

   // Reset asserts asynchronously but is released on a clock edge.
   logic [1:0] rst_sync;
   logic       rst_int_n;

   always_ff @(posedge rgb_clk or negedge rst_n) begin
      if (!rst_n) rst_sync <= '0;
      else        rst_sync <= {rst_sync[0], 1'b1};
   end
   assign rst_int_n = rst_sync[1];

   logic                          de_q, vs_q, skip_q;
   logic [CHANNEL_COUNT*LANE_W-1:0] pack_q;
   logic [SLOT_W-1:0]             slot_q;
   logic [LEN_W-1:0]              line_len_q, first_w_q;
   logic [LCNT_W-1:0]             line_cnt_q;
   logic                          incons_q;
   logic [ACNT_W-1:0]             addr_cnt_q;
   logic [STAB_W-1:0]             stab_q;

   logic                          vs_act, frame_edge, pix, line_end, skip_next;
   logic                          batch_full, flush, wr_req, wr_ok, ovf_eff;
   logic [CHANNEL_COUNT*LANE_W-1:0] pack_fill, wr_word;
   logic [LCNT_W-1:0]             lines_inc, eff_lines;
   logic [LEN_W-1:0]              eff_width;
   logic                          line_bad, eff_incons, frame_real, accept, dims_same;
   logic [STAB_W-1:0]             stab_next;
   logic [BANK_W-1:0]             bank_next;

   assign vs_act     = (rgb_vs == vs_pol);
   assign frame_edge = vs_act & ~vs_q;
   // A line caught by a frame edge stays ignored until DE drops.
   assign skip_next  = frame_edge ? rgb_de : (skip_q & rgb_de);
   assign pix        = rgb_de & ~skip_q & ~frame_edge;
   assign line_end   = de_q & ~rgb_de & ~skip_q;

   always_comb begin
      pack_fill = pack_q;
      for (int c = 0; c < CHANNEL_COUNT; c++) begin
         for (int k = 0; k < BATCH_SIZE; k++) begin
            if (SLOT_W'(k) == slot_q)
               pack_fill[c*LANE_W + k*COLOR_WIDTH +: COLOR_WIDTH] =
                  rgb_color[c*COLOR_WIDTH +: COLOR_WIDTH];
         end
      end
   end

   assign batch_full = pix & (slot_q == SLOT_LAST);
   assign flush      = line_end & (slot_q != '0);
   assign wr_req     = batch_full | flush;
   assign wr_word    = batch_full ? pack_fill : pack_q;
   assign wr_ok      = wr_req & (addr_cnt_q != ADDR_LIMIT);
   assign ovf_eff    = overflow | (wr_req & (addr_cnt_q == ADDR_LIMIT));

   assign lines_inc  = (line_cnt_q == LCNT_SAT) ? LCNT_SAT : line_cnt_q + 1'b1;
   assign line_bad   = ((line_cnt_q != '0) && (line_len_q != first_w_q)) ||
                       (line_len_q > LEN_MAX) || (lines_inc > LCNT_MAX);

   // A line ending on the same edge as the frame still belongs to that frame.
   assign eff_lines  = line_end ? lines_inc : line_cnt_q;
   assign eff_width  = (line_end && (line_cnt_q == '0)) ? line_len_q : first_w_q;
   assign eff_incons = incons_q | (line_end & line_bad) | (frame_edge & rgb_de);
   assign frame_real = frame_edge & (eff_lines != '0);
   assign accept     = ~eff_incons & ~ovf_eff;
   assign dims_same  = (eff_width == LEN_W'(image_width)) &&
                       (eff_lines == LCNT_W'(image_height));
   assign bank_next  = (wr_bank == BANK_LAST) ? '0 : wr_bank + 1'b1;

   always_comb begin
      stab_next = stab_q;
      if (frame_real) begin
         if (!accept)        stab_next = '0;
         else if (!dims_same) stab_next = STAB_W'(1);
         else if (stab_q != STAB_SAT) stab_next = stab_q + 1'b1;
      end
   end

   always_ff @(posedge rgb_clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         de_q         <= 1'b0;
         vs_q         <= 1'b0;
         skip_q       <= 1'b0;
         pack_q       <= '0;
         slot_q       <= '0;
         line_len_q   <= '0;
         first_w_q    <= '0;
         line_cnt_q   <= '0;
         incons_q     <= 1'b0;
         addr_cnt_q   <= '0;
         stab_q       <= '0;
         wr_data      <= '0;
         wr_addr      <= '0;
         wr_bank      <= '0;
         wr_en        <= 1'b0;
         frame_done   <= 1'b0;
         ready_bank   <= '0;
         overflow     <= 1'b0;
         image_width  <= '0;
         image_height <= '0;
         image_valid  <= 1'b0;
      end else begin
         de_q       <= rgb_de;
         vs_q       <= vs_act;
         skip_q     <= skip_next;
         wr_en      <= wr_ok;
         frame_done <= frame_real;
         overflow   <= frame_edge ? 1'b0 : ovf_eff;
         stab_q     <= stab_next;
         image_valid <= (stab_next >= STAB_SAT);

         if (wr_ok) begin
            wr_data <= wr_word;
            wr_addr <= addr_cnt_q[ADDR_W-1:0];
         end

         if (frame_edge)  addr_cnt_q <= '0;
         else if (wr_ok)  addr_cnt_q <= addr_cnt_q + 1'b1;

         if (frame_edge || batch_full || flush) begin
            pack_q <= '0;
            slot_q <= '0;
         end else if (pix) begin
            pack_q <= pack_fill;
            slot_q <= slot_q + 1'b1;
         end

         if (frame_edge || line_end) line_len_q <= '0;
         else if (pix && (line_len_q != LEN_SAT)) line_len_q <= line_len_q + 1'b1;

         if (frame_edge) begin
            line_cnt_q <= '0;
            first_w_q  <= '0;
            incons_q   <= 1'b0;
         end else if (line_end) begin
            line_cnt_q <= lines_inc;
            incons_q   <= incons_q | line_bad;
            if (line_cnt_q == '0) first_w_q <= line_len_q;
         end

         if (frame_real) begin
            ready_bank <= wr_bank;
            wr_bank    <= bank_next;
            if (accept) begin
               image_width  <= eff_width[IW_W-1:0];
               image_height <= eff_lines[IH_W-1:0];
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_video_input_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_video_input_packer
// Purpose  : Scoreboard bench for video_input_packer frame packing and geometry.
// Revision : 1.0 - initial release
// ============================================================================
module tb_video_input_packer;

   logic        clk = 1'b0;
   logic        rst_n, rgb_de, rgb_vs, vs_pol;
   logic [23:0] rgb_color;
   logic [95:0] wr_data;
   logic [8:0]  wr_addr;
   logic        wr_bank, wr_en, frame_done, ready_bank, overflow, image_valid;
   logic [6:0]  image_width, image_height;

   video_input_packer dut (
      .rgb_clk(clk), .rst_n(rst_n), .rgb_de(rgb_de), .rgb_vs(rgb_vs),
      .vs_pol(vs_pol), .rgb_color(rgb_color), .wr_data(wr_data),
      .wr_addr(wr_addr), .wr_bank(wr_bank), .wr_en(wr_en),
      .frame_done(frame_done), .ready_bank(ready_bank), .overflow(overflow),
      .image_width(image_width), .image_height(image_height),
      .image_valid(image_valid)
   );

   always #5 clk = ~clk;

   int          checks = 0, failures = 0;
   logic [8:0]  q_addr[$];
   logic        q_bank[$];
   logic [95:0] q_data[$];
   logic [95:0] m_pack;
   int          m_slot, m_addr, m_bank;
   int          last_addr;
   logic [31:0] first_lane0;
   bit          cap_first;

   // Write monitor: every DUT write is popped against the expected queue.
   always @(negedge clk) begin
      logic [8:0]  ea;
      logic        eb;
      logic [95:0] ed;
      if (rst_n && wr_en) begin
         checks++;
         if (q_addr.size() == 0) begin
            failures++;
            $display("FAIL unexpected_write addr=%0d data=%h", wr_addr, wr_data);
         end else begin
            ea = q_addr.pop_front();
            eb = q_bank.pop_front();
            ed = q_data.pop_front();
            if (wr_addr !== ea || wr_bank !== eb || wr_data !== ed) begin
               failures++;
               $display("FAIL write_word got addr=%0d bank=%0d data=%h expected addr=%0d bank=%0d data=%h",
                        wr_addr, wr_bank, wr_data, ea, eb, ed);
            end
         end
         last_addr = int'(wr_addr);
         if (cap_first) begin
            first_lane0 = wr_data[31:0];
            cap_first   = 1'b0;
         end
      end
   end

   task automatic push_word();
      if (m_addr < 480) begin
         q_addr.push_back(9'(m_addr));
         q_bank.push_back(m_bank[0]);
         q_data.push_back(m_pack);
         m_addr++;
      end
      m_pack = '0;
      m_slot = 0;
   endtask

   task automatic model_clear();
      m_pack = '0;
      m_slot = 0;
   endtask

   task automatic drive_pixel(input int k, input int id);
      logic [7:0] c0, c1, c2;
      c0 = 8'(k + 1);
      c1 = 8'(8'h80 + k);
      c2 = 8'(id);
      rgb_de    = 1'b1;
      rgb_color = {c2, c1, c0};
      m_pack[0*32 + m_slot*8 +: 8] = c0;
      m_pack[1*32 + m_slot*8 +: 8] = c1;
      m_pack[2*32 + m_slot*8 +: 8] = c2;
      m_slot++;
      if (m_slot == 4) push_word();
   endtask

   task automatic drive_line(input int len, input int id);
      for (int k = 0; k < len; k++) begin
         @(negedge clk);
         drive_pixel(k, id);
      end
      @(negedge clk);
      rgb_de = 1'b0;
      if (m_slot != 0) push_word();
      repeat (2) @(negedge clk);
   endtask

   task automatic end_frame(input int exp_w, input int exp_h, input bit exp_valid);
      int pulses = 0;
      @(negedge clk);
      rgb_vs = vs_pol;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (frame_done) begin
            pulses++;
            if (pulses == 1) begin
               checks++;
               if (image_width !== 7'(exp_w) || image_height !== 7'(exp_h)) begin
                  failures++;
                  $display("FAIL frame_dims got %0dx%0d expected %0dx%0d",
                           image_width, image_height, exp_w, exp_h);
               end
               checks++;
               if (image_valid !== exp_valid) begin
                  failures++;
                  $display("FAIL image_valid got %0b expected %0b", image_valid, exp_valid);
               end
               checks++;
               if (ready_bank !== m_bank[0] || wr_bank !== ~m_bank[0]) begin
                  failures++;
                  $display("FAIL banks got ready=%0d wr=%0d expected ready=%0d wr=%0d",
                           ready_bank, wr_bank, m_bank[0], ~m_bank[0]);
               end
               checks++;
               if (overflow !== 1'b0) begin
                  failures++;
                  $display("FAIL overflow_clear got %0b expected 0", overflow);
               end
            end
         end
      end
      checks++;
      if (pulses != 1) begin
         failures++;
         $display("FAIL frame_done_pulse got %0d pulses expected 1", pulses);
      end
      checks++;
      if (q_addr.size() != 0) begin
         failures++;
         $display("FAIL pending_writes got %0d outstanding expected 0", q_addr.size());
      end
      m_bank ^= 1;
      m_addr = 0;
      model_clear();
      rgb_vs = ~vs_pol;
      repeat (2) @(negedge clk);
   endtask

   task automatic run_frame(input int w, input int h, input int ew, input int eh, input bit ev);
      for (int l = 0; l < h; l++) drive_line(w, l);
      end_frame(ew, eh, ev);
   endtask

   task automatic check_all_zero(input string tag);
      checks++;
      if ({wr_en, frame_done, overflow, image_valid, wr_bank, ready_bank} !== 6'b0 ||
          wr_addr !== 9'd0 || wr_data !== 96'd0 || image_width !== 7'd0 || image_height !== 7'd0) begin
         failures++;
         $display("FAIL %s got en=%0b fd=%0b ovf=%0b v=%0b bank=%0d addr=%0d w=%0d h=%0d expected all zero",
                  tag, wr_en, frame_done, overflow, image_valid, wr_bank, wr_addr, image_width, image_height);
      end
   endtask

   task automatic apply_reset(input bit pol);
      rst_n  = 1'b0;
      rgb_de = 1'b0;
      vs_pol = pol;
      rgb_vs = ~pol;
      repeat (3) @(negedge clk);
      q_addr.delete(); q_bank.delete(); q_data.delete();
      m_bank = 0; m_addr = 0;
      model_clear();
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; rgb_de = 1'b0; vs_pol = 1'b0; rgb_vs = 1'b1; rgb_color = '0;
      repeat (3) @(negedge clk);
      check_all_zero("reset_state");
      apply_reset(1'b0);
   endtask

   task automatic test_basic();
      cap_first = 1'b1;
      run_frame(16, 8, 16, 8, 1'b0);
      checks++;
      if (first_lane0 !== 32'h04030201) begin
         failures++;
         $display("FAIL first_word got %h expected 04030201", first_lane0);
      end
      checks++;
      if (last_addr != 31) begin
         failures++;
         $display("FAIL last_addr_16 got %0d expected 31", last_addr);
      end
      run_frame(16, 8, 16, 8, 1'b1);
      run_frame(16, 8, 16, 8, 1'b1);
   endtask

   task automatic test_zero_line_frame();
      int pulses = 0;
      @(negedge clk);
      rgb_vs = vs_pol;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (frame_done) pulses++;
      end
      rgb_vs = ~vs_pol;
      repeat (2) @(negedge clk);
      checks++;
      if (pulses != 0 || wr_bank !== m_bank[0] || image_valid !== 1'b1) begin
         failures++;
         $display("FAIL empty_frame got pulses=%0d bank=%0d valid=%0b expected 0 %0d 1",
                  pulses, wr_bank, image_valid, m_bank[0]);
      end
   endtask

   task automatic test_partial_batch();
      run_frame(18, 8, 18, 8, 1'b0);
      checks++;
      if (last_addr != 39) begin
         failures++;
         $display("FAIL last_addr_18 got %0d expected 39", last_addr);
      end
      run_frame(18, 8, 18, 8, 1'b1);
   endtask

   task automatic test_bad_line();
      run_frame(16, 8, 16, 8, 1'b0);
      run_frame(16, 8, 16, 8, 1'b1);
      for (int l = 0; l < 8; l++) drive_line((l == 3) ? 15 : 16, l);
      end_frame(16, 8, 1'b0);
      run_frame(16, 8, 16, 8, 1'b0);
      run_frame(16, 8, 16, 8, 1'b1);
   endtask

   task automatic test_overflow();
      for (int l = 0; l < 64; l++) drive_line(64, l);
      checks++;
      if (overflow !== 1'b1 || last_addr != 479) begin
         failures++;
         $display("FAIL overflow_set got ovf=%0b last=%0d expected 1 479", overflow, last_addr);
      end
      end_frame(16, 8, 1'b0);
      run_frame(16, 8, 16, 8, 1'b0);
   endtask

   task automatic test_vs_mid_line();
      int pulses = 0;
      for (int l = 0; l < 3; l++) drive_line(16, l);
      @(negedge clk); drive_pixel(0, 3);
      @(negedge clk); drive_pixel(1, 3);
      @(negedge clk); rgb_vs = vs_pol; drive_pixel(2, 3); model_clear();
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (frame_done) begin
            pulses++;
            checks++;
            if (image_width !== 7'd16 || image_height !== 7'd8 || image_valid !== 1'b0 ||
                ready_bank !== m_bank[0]) begin
               failures++;
               $display("FAIL vs_mid_line got %0dx%0d v=%0b rb=%0d expected 16x8 v=0 rb=%0d",
                        image_width, image_height, image_valid, ready_bank, m_bank[0]);
            end
         end
         if (i < 2) begin
            drive_pixel(3 + i, 3);
            model_clear();
         end else begin
            rgb_de = 1'b0;
         end
      end
      checks++;
      if (pulses != 1 || q_addr.size() != 0) begin
         failures++;
         $display("FAIL vs_mid_pulse got pulses=%0d pending=%0d expected 1 0", pulses, q_addr.size());
      end
      m_bank ^= 1; m_addr = 0;
      rgb_vs = ~vs_pol;
      repeat (2) @(negedge clk);
      run_frame(16, 8, 16, 8, 1'b0);
   endtask

   task automatic test_reset_midframe();
      for (int l = 0; l < 3; l++) drive_line(16, l);
      drive_line(4, 3);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_all_zero("reset_midframe");
      apply_reset(1'b0);
      run_frame(16, 8, 16, 8, 1'b0);
   endtask

   task automatic test_vs_pol_high();
      apply_reset(1'b1);
      cap_first = 1'b1;
      run_frame(16, 8, 16, 8, 1'b0);
      checks++;
      if (first_lane0 !== 32'h04030201 || last_addr != 31) begin
         failures++;
         $display("FAIL vs_pol_high got first=%h last=%0d expected 04030201 31", first_lane0, last_addr);
      end
      run_frame(16, 8, 16, 8, 1'b1);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_zero_line_frame();
      test_partial_batch();
      test_bad_line();
      test_overflow();
      test_vs_mid_line();
      test_reset_midframe();
      test_vs_pol_high();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/video_input_packer.md
Name: video_input_packer

Overview:
Parametrised successor of the current input stage. Samples a DE/VSYNC pixel stream on the pixel clock and packs BATCH_SIZE pixels per channel into one RAM word. It writes those words into a double-buffered block-RAM region. It also measures frame geometry and raises image_valid only after several identical, consistent frames, so downstream matrix logic reads a settled bank.

Parameters:
CHANNEL_COUNT, 3, number of colour channels (one RAM lane each)
COLOR_WIDTH, 8, bits per channel sample
BATCH_SIZE, 4, pixels packed per RAM word
BLOCK_DEPTH, 480, words per bank per lane
BANK_COUNT, 2, number of frame banks (>=1)
MAX_WIDTH, 64, largest accepted line length in pixels
MAX_HEIGHT, 64, largest accepted line count
STABLE_FRAMES, 2, identical consistent frames required before image_valid

Ports:
rgb_clk  in  1  pixel clock; all logic on rising edge
rst_n  in  1  asynchronous active-low reset
rgb_de  in  1  data enable; pixel valid when high
rgb_vs  in  1  vertical sync, raw level
vs_pol  in  1  active level of rgb_vs (0 = active-low); quasi-static
rgb_color  in  [CHANNEL_COUNT] x COLOR_WIDTH  pixel samples
wr_data  out  [CHANNEL_COUNT] x COLOR_WIDTH*BATCH_SIZE  packed word per lane
wr_addr  out  $clog2(BLOCK_DEPTH)  word address within bank
wr_bank  out  $clog2(BANK_COUNT) (min 1)  bank currently written
wr_en  out  1  write strobe, one cycle per word
frame_done  out  1  one-cycle pulse at accepted frame end
ready_bank  out  $clog2(BANK_COUNT) (min 1)  last completed bank
overflow  out  1  words dropped in current frame (sticky per frame)
image_width  out  $clog2(MAX_WIDTH+1)  last accepted width
image_height  out  $clog2(MAX_HEIGHT+1)  last accepted height
image_valid  out  1  geometry stable

Behaviour:
- Reset (async assert, sync deassert inside block): all outputs 0; counters, bank and stability count cleared; input history registers set to inactive.
- vs_act = (rgb_vs == vs_pol). Frame end is the inactive->active edge of registered vs_act. Line end is the falling edge of rgb_de.
- Packing: pixel k of a batch goes to bits [k*COLOR_WIDTH +: COLOR_WIDTH], so the first pixel is in the LSBs.
- Full-batch write: when the BATCH_SIZE-th pixel is sampled, wr_en=1 on the next cycle. wr_data and wr_addr are valid with it. wr_addr then increments.
- Partial batch at line end: flushed on the cycle after DE falls. Unused slots are zero. Lines never share words.
- wr_addr resets to 0 at every frame end.
- Overflow: a write when wr_addr would be BLOCK_DEPTH is suppressed (wr_en stays 0) and sets overflow. overflow clears at frame end.
- Line length: counted per line, saturating at MAX_WIDTH+1.
- Frame width: the first line's count. The frame is inconsistent if any later line differs, a count exceeds MAX_WIDTH, or the line count exceeds MAX_HEIGHT (the line counter saturates).
- Frame end with zero lines: ignored entirely. No pulse, no bank change, stability count unchanged.
- Frame end with at least one line:
  - frame_done pulses.
  - ready_bank <= wr_bank.
  - wr_bank <= (wr_bank+1) mod BANK_COUNT.
  - If consistent and not overflowed: image_width/height <= measured values. The stability count increments (saturating at STABLE_FRAMES) if the dims equal the previous accepted dims, otherwise it is set to 1.
  - If inconsistent or overflowed: the stability count is set to 0 and the dims are held.
- image_valid = (stability count >= STABLE_FRAMES), registered.
- Frame edge while rgb_de=1: the in-progress line is discarded (not counted, partial batch not written) and the frame is marked inconsistent. Frame end processing then proceeds as above.
- DE high during active VS: pixels are accepted normally; VS only matters on its edge.
- wr_en never asserts on two sources in one cycle. A line-end flush and a full batch cannot coincide, because a full batch empties the pack register.

Test Plan:
- 16x8 frames, BATCH_SIZE=4, vs_pol=0, channel0 pixels 1..16 per line -> 4 writes per line, addresses 0..31, first word lane0 = 0x04030201. Frame 1 end: frame_done, width 16, height 8, image_valid 0. Frame 2 end: image_valid 1. wr_bank alternates 0,1,0.
- 18-pixel lines -> 5 words per line. The 5th word lane0 = 0x00001211. Per frame, address reaches 39.
- 64x64 frame (1024 words) -> last write at address 479, overflow 1, dims held, image_valid drops to 0. The next good frame clears overflow.
- Stable 16x8 frames, then one 15-pixel line inside a frame -> that frame is rejected, image_valid falls. It rises again after 2 more good frames.
- VS edge mid-line with DE high -> that line is not counted and has no flush write. Separately, vs_pol=1 with active-high pulses gives results identical to the first scenario.
- rst_n low mid-frame -> all outputs 0 immediately. The next full frame starts writing at address 0, bank 0.
